apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 8, APB address width.
REQ-002 Parameter DATA_W, default 8, APB data width (matches exe unit operand width M).
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS cycles with i_pready low before abort (>=2).
REQ-004 i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 i_req  input  1  command request; accepted only when o_ready=1.
REQ-007 i_write  input  1  1=write, 0=read; sampled with accepted i_req.
REQ-008 i_addr  input  ADDR_W  target register address; sampled with accepted i_req.
REQ-009 i_wdata  input  DATA_W  write data (e.g. argA/argB); sampled with accepted i_req.
REQ-010 o_ready  output  1  high only in IDLE; command may be accepted this cycle.
REQ-011 o_done  output  1  one-cycle completion pulse.
REQ-012 o_rdata  output  DATA_W  last successful read data.
REQ-013 o_err  output  1  valid with o_done; slave error or timeout.
REQ-014 o_timeout  output  1  valid with o_done; abort due to TIMEOUT.
REQ-015 o_psel, o_penable, o_pwrite  output  1 each  APB control.
REQ-016 o_paddr  output  ADDR_W; o_pwdata  output  DATA_W  APB address/write data.
REQ-017 i_prdata  input  DATA_W; i_pready  input  1; i_pslverr  input  1  APB slave response.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS; all outputs registered.
REQ-019 IDLE: o_ready=1, o_psel=0, o_penable=0; on i_req=1 latch i_write/i_addr/i_wdata, go SETUP.
REQ-020 SETUP: o_psel=1, o_penable=0, o_paddr/o_pwrite/o_pwdata = latched values; unconditionally go ACCESS next cycle.
REQ-021 ACCESS: o_psel=1, o_penable=1; address, data, pwrite held stable from SETUP until exit.
REQ-022 ACCESS with i_pready=1: go IDLE; o_done=1 next cycle; o_err=i_pslverr; o_timeout=0.
REQ-023 On read completion with i_pslverr=0, o_rdata captures i_prdata; on write, error or timeout o_rdata holds.
REQ-024 Wait counter clears on SETUP entry, increments per ACCESS cycle with i_pready=0.
REQ-025 When counter reaches TIMEOUT with i_pready still 0: go IDLE, o_done=1, o_err=1, o_timeout=1; i_pready=1 in that same cycle wins (normal completion).
REQ-026 Minimum latency: request accepted edge N -> SETUP N+1 -> ACCESS N+2 -> o_done high cycle N+3 (zero wait states).
REQ-027 i_req while o_ready=0 ignored, no queuing; new command accepted in cycle o_done is high (o_ready=1 there).
REQ-028 o_done, o_err, o_timeout low in every cycle except the completion pulse.
REQ-029 In IDLE, o_paddr/o_pwdata/o_pwrite hold last driven values.

Reset
REQ-030 i_rst=1 forces IDLE immediately, independent of i_clk, including mid-SETUP/ACCESS.
REQ-031 Reset values: o_psel=0, o_penable=0, o_pwrite=0, o_paddr=0, o_pwdata=0, o_rdata=0, o_done=0, o_err=0, o_timeout=0, o_ready=1, wait counter=0.
REQ-032 Transfer interrupted by reset produces no o_done pulse.

Structure
REQ-033 Shared package apb_pkg holds state enum (IDLE, SETUP, ACCESS) and default ADDR_W/DATA_W/TIMEOUT constants, shared with the APB slave exe unit.
REQ-034 Single module, no sub-modules; wait counter width $clog2(TIMEOUT+1).

Verification
REQ-035 Write addr 0x00 data 7, i_pready=1 in first ACCESS -> o_paddr=0x00, o_pwdata=0x07, o_pwrite=1; o_done 3 cycles after accept, o_err=0.
REQ-036 Write addr 0x01 data 0xFE (-2) then read addr 0x02, slave returns 0x80 after 2 wait states -> read o_done at cycle N+5, o_rdata=0x80, signals stable through ACCESS.
REQ-037 Read addr 0x03 with i_pslverr=1, i_prdata=0x55 -> o_done=1, o_err=1, o_timeout=0, o_rdata unchanged (0x80).
REQ-038 Read with i_pready held 0, TIMEOUT=16 -> abort after 16 ACCESS wait cycles; o_done=o_err=o_timeout=1; o_psel=0 next cycle.
REQ-039 Assert i_rst mid-ACCESS -> o_psel/o_penable low before next clock edge, no o_done, o_ready=1; next command completes normally.
REQ-040 i_req pulsed during ACCESS -> ignored; exactly one transfer on APB.

Source files
------------

// File: rtl/apb_pkg.sv
// APB master/slave shared definitions.
// FSM state encodings and default bus geometry.
package apb_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  function automatic int cnt_w(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/apb_master.sv
// Single-command APB master with wait-state timeout.
// All outputs are registered; state and outputs update together.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ready,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err,
  output logic              o_timeout,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);

  localparam int CW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;

  // The latched command lives directly in the APB output registers,
  // so address/data/pwrite stay put through ACCESS and across IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      o_ready   <= 1'b1;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_timeout <= 1'b0;
      o_rdata   <= '0;
      o_psel    <= 1'b0;
      o_penable <= 1'b0;
      o_pwrite  <= 1'b0;
      o_paddr   <= '0;
      o_pwdata  <= '0;
    end else begin
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_req) begin
            state     <= ST_SETUP;
            wait_cnt  <= '0;
            o_ready   <= 1'b0;
            o_psel    <= 1'b1;
            o_penable <= 1'b0;
            o_pwrite  <= i_write;
            o_paddr   <= i_addr;
            o_pwdata  <= i_wdata;
          end
        end
        ST_SETUP: begin
          state     <= ST_ACCESS;
          o_penable <= 1'b1;
        end
        ST_ACCESS: begin
          if (i_pready) begin
            state     <= ST_IDLE;
            o_ready   <= 1'b1;
            o_psel    <= 1'b0;
            o_penable <= 1'b0;
            o_done    <= 1'b1;
            o_err     <= i_pslverr;
            if (!o_pwrite && !i_pslverr) begin
              o_rdata <= i_prdata;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            // This is the TIMEOUT-th wait cycle: abort.
            state     <= ST_IDLE;
            o_ready   <= 1'b1;
            o_psel    <= 1'b0;
            o_penable <= 1'b0;
            o_done    <= 1'b1;
            o_err     <= 1'b1;
            o_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          o_ready   <= 1'b1;
          o_psel    <= 1'b0;
          o_penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_apb_master;

  logic       clk;
  logic       rst;
  logic       req;
  logic       write;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic       done;
  logic [7:0] rdata;
  logic       err;
  logic       tmo;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  int checks = 0;
  int fails  = 0;
  int setups = 0;

  apb_master dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .i_write   (write),
    .i_addr    (addr),
    .i_wdata   (wdata),
    .o_ready   (ready),
    .o_done    (done),
    .o_rdata   (rdata),
    .o_err     (err),
    .o_timeout (tmo),
    .o_psel    (psel),
    .o_penable (penable),
    .o_pwrite  (pwrite),
    .o_paddr   (paddr),
    .o_pwdata  (pwdata),
    .i_prdata  (prdata),
    .i_pready  (pready),
    .i_pslverr (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (psel && !penable) setups <= setups + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Drive a command for one rising edge; returns at the SETUP sample point.
  task automatic issue(input logic w, input logic [7:0] a,
                       input logic [7:0] d);
    req   = 1'b1;
    write = w;
    addr  = a;
    wdata = d;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({psel, penable, pwrite} !== 3'b000) begin
      fails++;
      $display("FAIL rst_ctrl got %b want 000", {psel, penable, pwrite});
    end
    checks++;
    if ({paddr, pwdata, rdata} !== 24'h0) begin
      fails++;
      $display("FAIL rst_data got %h want 0", {paddr, pwdata, rdata});
    end
    checks++;
    if ({ready, done, err, tmo} !== 4'b1000) begin
      fails++;
      $display("FAIL rst_status got %b want 1000", {ready, done, err, tmo});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_basic;
    pready  = 1'b1;
    pslverr = 1'b0;
    issue(1'b1, 8'h00, 8'h07);
    checks++;
    if ({psel, penable, pwrite, ready} !== 4'b1010) begin
      fails++;
      $display("FAIL wr_setup_ctrl got %b want 1010",
               {psel, penable, pwrite, ready});
    end
    checks++;
    if ({paddr, pwdata} !== 16'h0007) begin
      fails++;
      $display("FAIL wr_setup_bus got %h want 0007", {paddr, pwdata});
    end
    @(negedge clk);
    checks++;
    if ({psel, penable, done} !== 3'b110) begin
      fails++;
      $display("FAIL wr_access got %b want 110", {psel, penable, done});
    end
    @(negedge clk);
    checks++;
    if ({done, err, tmo, ready, psel} !== 5'b10010) begin
      fails++;
      $display("FAIL wr_done got %b want 10010",
               {done, err, tmo, ready, psel});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL wr_done_pulse got %b want 0", done);
    end
  endtask

  task automatic test_wait_read;
    pready = 1'b1;
    issue(1'b1, 8'h01, 8'hFE);
    repeat (2) @(negedge clk);
    checks++;
    if ({done, pwdata} !== 9'h1FE) begin
      fails++;
      $display("FAIL wr2_done got %h want 1fe", {done, pwdata});
    end
    pready = 1'b0;
    prdata = 8'h11;
    issue(1'b0, 8'h02, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({psel, penable, pwrite, paddr, done} !== {3'b110, 8'h02, 1'b0}) begin
        fails++;
        $display("FAIL rd_wait_stable[%0d] got %b", i,
                 {psel, penable, pwrite, paddr, done});
      end
    end
    pready = 1'b1;
    prdata = 8'h80;
    @(negedge clk);
    checks++;
    if ({done, err, rdata} !== {2'b10, 8'h80}) begin
      fails++;
      $display("FAIL rd_wait_done got %h want 280", {done, err, rdata});
    end
  endtask

  task automatic test_slverr;
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 8'h55;
    issue(1'b0, 8'h03, 8'h00);
    repeat (2) @(negedge clk);
    checks++;
    if ({done, err, tmo, rdata} !== {3'b110, 8'h80}) begin
      fails++;
      $display("FAIL slverr got %h want 680", {done, err, tmo, rdata});
    end
    pslverr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int n;
    pready = 1'b0;
    prdata = 8'hAA;
    issue(1'b0, 8'h04, 8'h00);
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 18) begin
      fails++;
      $display("FAIL tmo_latency got %0d want 18", n);
    end
    checks++;
    if ({done, err, tmo, psel, penable, rdata} !== {5'b11100, 8'h80}) begin
      fails++;
      $display("FAIL tmo_flags got %b",
               {done, err, tmo, psel, penable, rdata});
    end
    @(negedge clk);
    checks++;
    if ({done, err, tmo} !== 3'b000) begin
      fails++;
      $display("FAIL tmo_pulse got %b want 000", {done, err, tmo});
    end
  endtask

  task automatic test_reset_mid;
    int dn;
    pready = 1'b0;
    issue(1'b1, 8'h09, 8'h33);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({psel, penable, ready} !== 3'b001) begin
      fails++;
      $display("FAIL rst_mid got %b want 001", {psel, penable, ready});
    end
    @(negedge clk);
    rst    = 1'b0;
    pready = 1'b1;
    dn     = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dn++;
    end
    checks++;
    if (dn !== 0) begin
      fails++;
      $display("FAIL rst_no_done got %0d want 0", dn);
    end
    issue(1'b1, 8'h05, 8'h3C);
    repeat (2) @(negedge clk);
    checks++;
    if ({done, err, pwrite, paddr, pwdata} !== {3'b101, 8'h05, 8'h3C}) begin
      fails++;
      $display("FAIL rst_recover got %h",
               {done, err, pwrite, paddr, pwdata});
    end
  endtask

  task automatic test_req_ignored;
    int dn;
    pready = 1'b0;
    setups = 0;
    issue(1'b1, 8'h10, 8'hA5);
    @(negedge clk);
    req   = 1'b1;
    write = 1'b0;
    addr  = 8'h20;
    @(negedge clk);
    req    = 1'b0;
    pready = 1'b1;
    checks++;
    if ({ready, paddr, pwrite} !== {1'b0, 8'h10, 1'b1}) begin
      fails++;
      $display("FAIL ign_hold got %h", {ready, paddr, pwrite});
    end
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dn++;
    end
    checks++;
    if (dn !== 1 || setups !== 1) begin
      fails++;
      $display("FAIL ign_count done=%0d setups=%0d want 1 1", dn, setups);
    end
  endtask

  task automatic test_back_to_back;
    pready = 1'b1;
    prdata = 8'h42;
    issue(1'b1, 8'h06, 8'h01);
    repeat (2) @(negedge clk);
    checks++;
    if ({done, ready} !== 2'b11) begin
      fails++;
      $display("FAIL b2b_first got %b want 11", {done, ready});
    end
    issue(1'b0, 8'h07, 8'h00);
    checks++;
    if ({psel, penable, pwrite, paddr} !== {3'b100, 8'h07}) begin
      fails++;
      $display("FAIL b2b_setup got %h", {psel, penable, pwrite, paddr});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({done, err, rdata} !== {2'b10, 8'h42}) begin
      fails++;
      $display("FAIL b2b_read got %h want 242", {done, err, rdata});
    end
  endtask

  initial begin
    rst     = 1'b1;
    req     = 1'b0;
    write   = 1'b0;
    addr    = 8'h00;
    wdata   = 8'h00;
    prdata  = 8'h00;
    pready  = 1'b0;
    pslverr = 1'b0;
    test_reset();
    test_write_basic();
    test_wait_read();
    test_slverr();
    test_timeout();
    test_reset_mid();
    test_req_ignored();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
